// File: rtl/byte_data_memory.sv
// byte_data_memory
//   Single-port, byte-addressed data memory for the MEM stage. Supports byte,
//   halfword and word stores/loads, optional sign extension, and a registered
//   one-cycle load result. After reset a clear engine sweeps every word to
//   INIT_VALUE, one word per cycle, while busy is high.
//
//   Storage is split into four byte lanes (lane 0 = bits [7:0] of a word), so a
//   store only has to enable the lanes it touches.
//
// Parameters
//   DEPTH       number of 32-bit words (power of two, >= 4)
//   ADDR_WIDTH  byte-address width, log2(DEPTH)+2
//   INIT_VALUE  word value written by the clear sweep
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   address       byte address (word = [ADDR_WIDTH-1:2], lane = [1:0])
//   writeEnabled  store request
//   readEnabled   load request (dropped if writeEnabled is also high)
//   accessSize    00 byte, 01 halfword, 1x word
//   signExtend    loads: 1 sign-extend, 0 zero-extend
//   writeInput    right-aligned store data
//   readResult    extended load data, held until the next accepted load
//   readValid     one-cycle pulse the cycle after an accepted load
//   busy          clear sweep in progress, requests ignored
//   misaligned    one-cycle pulse after a misaligned accepted access
//
// Build option
//   DM_MISALIGN_CHECK_EN  when defined, misaligned halfword/word accesses are
//                         flagged: stores are suppressed, loads return 0.
//                         When undefined, misaligned is tied low and the
//                         access is performed at the forced-aligned position.

module byte_data_memory_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wd,
  output logic [7:0]       rd
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock)
    if (we) mem[idx] <= wd;

  assign rd = mem[idx];
endmodule

module byte_data_memory #(
  parameter int          DEPTH      = 1024,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  writeEnabled,
  input  logic                  readEnabled,
  input  logic [1:0]            accessSize,
  input  logic                  signExtend,
  input  logic [31:0]           writeInput,
  output logic [31:0]           readResult,
  output logic                  readValid,
  output logic                  busy,
  output logic                  misaligned
);
  localparam int NUM_LANES = 4;
  localparam int IDX_W     = $clog2(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + IDX_W'(1);
      if (cnt == IDX_W'(DEPTH - 1)) state_nxt = IDLE;
    end
  end

  assign busy = (state == CLEAR);

  logic             idle, is_byte, is_half, is_word, mis;
  logic [1:0]       lane;
  logic [IDX_W-1:0] widx;

  assign idle    = (state == IDLE);
  assign lane    = address[1:0];
  assign widx    = address[ADDR_WIDTH-1:2];
  assign is_byte = (accessSize == 2'b00);
  assign is_half = (accessSize == 2'b01);
  assign is_word = accessSize[1];

`ifdef DM_MISALIGN_CHECK_EN
  assign mis = (is_half && address[0]) || (is_word && (address[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  logic st_go, ld_go, acc_go;

  // A simultaneous load is dropped in favour of the store.
  assign st_go  = idle && writeEnabled && !mis;
  assign ld_go  = idle && readEnabled && !writeEnabled;
  assign acc_go = idle && (writeEnabled || readEnabled);

  logic [IDX_W-1:0]                lane_idx;
  logic [NUM_LANES-1:0][7:0]       lane_rd;

  // The sweep borrows the single port while busy; user requests are ignored.
  assign lane_idx = busy ? cnt : widx;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic       sel, we;
    logic [7:0] wd;

    always_comb begin
      sel = 1'b1;
      if (is_byte)      sel = (lane == 2'(g));
      else if (is_half) sel = (address[1] == 1'(g / 2));
    end

    // Right-aligned store data: byte replicates [7:0], half maps [15:0]
    // onto the selected lane pair.
    always_comb begin
      wd = writeInput[8*g +: 8];
      if (is_byte)      wd = writeInput[7:0];
      else if (is_half) wd = writeInput[8*(g % 2) +: 8];
      if (busy)         wd = INIT_VALUE[8*g +: 8];
    end

    assign we = busy || (st_go && sel);

    byte_data_memory_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clock (clock),
      .we    (we),
      .idx   (lane_idx),
      .wd    (wd),
      .rd    (lane_rd[g])
    );
  end

  logic [31:0] rword, shifted, ld_data;

  assign rword = lane_rd;

  always_comb begin
    shifted = rword;
    if (is_byte)      shifted = rword >> {lane, 3'b000};
    else if (is_half) shifted = rword >> {address[1], 4'b0000};

    ld_data = shifted;
    if (is_byte)      ld_data = {{24{signExtend & shifted[7]}},  shifted[7:0]};
    else if (is_half) ld_data = {{16{signExtend & shifted[15]}}, shifted[15:0]};
    if (mis)          ld_data = '0;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      readResult <= '0;
      readValid  <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      readValid  <= ld_go;
      misaligned <= acc_go && mis;
      if (ld_go) readResult <= ld_data;
    end
endmodule

// File: tb/tb_byte_data_memory.sv
module tb_byte_data_memory;
  localparam int          DEPTH = 1024;
  localparam int          AW    = 12;
  localparam logic [31:0] INIT  = 32'h0000_0000;
`ifdef DM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clock, reset;
  logic [AW-1:0] address;
  logic          writeEnabled, readEnabled, signExtend;
  logic [1:0]    accessSize;
  logic [31:0]   writeInput, readResult;
  logic          readValid, busy, misaligned;

  byte_data_memory #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_VALUE(INIT)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .writeEnabled (writeEnabled),
    .readEnabled  (readEnabled),
    .accessSize   (accessSize),
    .signExtend   (signExtend),
    .writeInput   (writeInput),
    .readResult   (readResult),
    .readValid    (readValid),
    .busy         (busy),
    .misaligned   (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: flat byte array, little-endian words.
  logic [7:0]  mem_m [DEPTH*4];
  int          sweep_left;
  logic [31:0] exp_res;
  int          n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input int a, input logic [1:0] sz);
    return CHK && ((a % nbytes(sz)) != 0);
  endfunction

  function automatic logic [31:0] model_ld(input int a, input logic [1:0] sz, input logic sx);
    int          n    = nbytes(sz);
    int          base = a - (a % n);
    logic [31:0] v    = '0;
    if (is_mis(a, sz)) return '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[base + k];
    if (sx && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic model_st(input int a, input logic [1:0] sz, input logic [31:0] d);
    int n    = nbytes(sz);
    int base = a - (a % n);
    if (is_mis(a, sz)) return;
    for (int k = 0; k < n; k++) mem_m[base + k] = d[8*k +: 8];
  endtask

  // One clock: drive a request, advance past the edge, compare every output.
  task automatic step(input logic we, input logic re, input logic [1:0] sz,
                      input logic sx, input logic [AW-1:0] a, input logic [31:0] d);
    bit idle, exp_vld, exp_mis;
    writeEnabled = we; readEnabled = re; accessSize = sz;
    signExtend = sx; address = a; writeInput = d;
    idle    = (sweep_left == 0);
    exp_vld = idle && re && !we;
    exp_mis = idle && (we || re) && is_mis(int'(a), sz);
    if (exp_vld) exp_res = model_ld(int'(a), sz, sx);
    @(posedge clock); #1;
    if (idle && we) model_st(int'(a), sz, d);
    if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0)
        for (int i = 0; i < DEPTH*4; i++) mem_m[i] = INIT[8*(i%4) +: 8];
    end
    chk("busy", 32'(busy), 32'(sweep_left > 0));
    chk("readValid", 32'(readValid), 32'(exp_vld));
    chk("misaligned", 32'(misaligned), 32'(exp_mis));
    chk("readResult", readResult, exp_res);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
  endtask

  task automatic rand_step(input int amax);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, amax));
    step(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    writeEnabled = 0; readEnabled = 0; accessSize = 0;
    signExtend = 0; address = '0; writeInput = '0;
    repeat (hold) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_readValid", 32'(readValid), 32'd0);
    chk("rst_readResult", readResult, 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    exp_res    = '0;
    sweep_left = DEPTH;
    reset      = 1'b1;
  endtask

  // Runs until busy drops (bounded); returns the busy cycle count.
  task automatic sweep_count(input bit with_req, output int nb);
    nb = 0;
    for (int i = 0; i < 2*DEPTH && busy; i++) begin
      nb++;
      if (with_req) rand_step(255); else idle_step();
    end
    while (sweep_left > 0) idle_step();
  endtask

  initial begin
    int nb;
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    #2;
    do_reset(5);
    sweep_count(1'b0, nb);
    chk("busy_len", 32'(nb), 32'(DEPTH));

    step(0, 1, 2'b10, 0, 12'h000, 0);
    chk("ld_init", readResult, 32'h0000_0000);
    idle_step();
    chk("vld_pulse", 32'(readValid), 32'd0);

    step(1, 0, 2'b10, 0, 12'h010, 32'h8765_4321);
    step(1, 0, 2'b00, 0, 12'h011, 32'h0000_00AA);
    step(0, 1, 2'b10, 0, 12'h010, 0);
    chk("byte_merge", readResult, 32'h8765_AA21);
    step(0, 1, 2'b00, 1, 12'h013, 0);
    chk("lb_sext", readResult, 32'hFFFF_FF87);
    step(0, 1, 2'b00, 0, 12'h013, 0);
    chk("lb_zext", readResult, 32'h0000_0087);
    step(0, 1, 2'b01, 1, 12'h012, 0);
    chk("lh_sext", readResult, 32'hFFFF_8765);

    step(1, 1, 2'b10, 0, 12'h020, 32'h1234_5678);
    chk("wr_rd_drop", 32'(readValid), 32'd0);
    step(0, 1, 2'b10, 0, 12'h020, 0);
    chk("ld_after_st", readResult, 32'h1234_5678);

    step(1, 0, 2'b10, 0, 12'h021, 32'hDEAD_BEEF);
    chk("mis_store_flag", 32'(misaligned), 32'(CHK));
    step(0, 1, 2'b10, 0, 12'h020, 0);
    chk("mis_store_mem", readResult, CHK ? 32'h1234_5678 : 32'hDEAD_BEEF);

    repeat (400) rand_step(63);

    // Reset in the middle of a sweep, then again; requests while busy.
    do_reset(3);
    repeat (100) idle_step();
    do_reset(2);
    sweep_count(1'b1, nb);
    chk("busy_len_restart", 32'(nb), 32'(DEPTH));

    repeat (400) rand_step(255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
